frame_transmitter: RTL and testbench

Transmit end of the framed byte link: accepts payload bytes on a valid/ready stream, buffers them in two 10-byte ping-pong banks, and emits one byte per clock on `tx_data`, either an idle filler or a 12-byte frame (2-byte header, 10 payload bytes). It sits upstream of the frame aligner. Its frames must drive the aligner's byte position (0..11) and three-frame `frame_detect` lock, including back-to-back frames and deliberately corrupted headers.

---
 rtl/frame_transmitter_if.sv | 25 ++
 rtl/frame_transmitter.sv | 164 ++++++++++++++++
 tb/tb_frame_transmitter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_transmitter_if.sv
// Bundles the payload stream, frame-control inputs and the transmitted byte stream of
// frame_transmitter.
interface frame_transmitter_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hdr_sel;
  logic        err_inject;
  logic        tx_enable;
  logic [7:0]  tx_data;
  logic        tx_sof;
  logic        tx_active;
  logic [3:0]  tx_byte_position;
  logic [15:0] frames_sent;

  modport master (
    output in_data, in_valid, hdr_sel, err_inject, tx_enable,
    input  in_ready, tx_data, tx_sof, tx_active, tx_byte_position, frames_sent
  );

  modport slave (
    input  in_data, in_valid, hdr_sel, err_inject, tx_enable,
    output in_ready, tx_data, tx_sof, tx_active, tx_byte_position, frames_sent
  );
endinterface

// File: rtl/frame_transmitter.sv
// Framed byte link transmitter: two 10-byte ping-pong payload banks feeding a registered
// 12-byte frame emitter (2-byte header + 10 payload bytes) with an idle filler between frames.
module frame_transmitter #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input logic clk,
  input logic reset,
  frame_transmitter_if.slave bus
);

  localparam int unsigned BankBytes = 10;
  localparam logic [3:0]  LastWrPtr = 4'd9;
  localparam logic [3:0]  LastPos   = 4'd11;

  typedef enum logic [1:0] {
    StIdle,
    StHdrLsb,
    StHdrMsb,
    StPayload
  } state_e;

  // Write side
  logic [1:0] full_q;
  logic       wr_bank_q;
  logic [3:0] wr_ptr_q;
  logic [1:0] hdr_sel_q;
  logic [1:0] err_q;
  logic [7:0] mem_q [2][BankBytes];

  // Read side
  state_e      state_q;
  logic        rd_bank_q;
  logic [3:0]  pos_q;
  logic [7:0]  tx_data_q;
  logic        tx_sof_q;
  logic        tx_active_q;
  logic [15:0] frames_sent_q;

  logic in_ready;
  logic accept;
  logic release_bank;
  logic nxt_bank;

  assign in_ready     = ~full_q[wr_bank_q];
  assign accept       = bus.in_valid & in_ready;
  assign release_bank = (state_q == StPayload) && (pos_q == LastPos);
  assign nxt_bank     = ~rd_bank_q;

  assign bus.in_ready         = in_ready;
  assign bus.tx_data          = tx_data_q;
  assign bus.tx_sof           = tx_sof_q;
  assign bus.tx_active        = tx_active_q;
  assign bus.tx_byte_position = pos_q;
  assign bus.frames_sent      = frames_sent_q;

  function automatic logic [7:0] hdr_lsb(input logic sel);
    return sel ? 8'h55 : 8'hAA;
  endfunction

  function automatic logic [7:0] hdr_msb(input logic sel, input logic err);
    logic [7:0] msb;
    msb = sel ? 8'hBA : 8'hAF;
    return err ? ~msb : msb;
  endfunction

  // Payload storage carries no reset: a bank's contents are only read once its full flag is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_bank_q][wr_ptr_q] <= bus.in_data;
    end
  end

  // Release and fill always target different banks, so both updates can land on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= 4'd0;
      hdr_sel_q <= 2'b00;
      err_q     <= 2'b00;
    end else begin
      if (release_bank) begin
        full_q[rd_bank_q] <= 1'b0;
      end
      if (accept) begin
        if (wr_ptr_q == LastWrPtr) begin
          full_q[wr_bank_q]    <= 1'b1;
          hdr_sel_q[wr_bank_q] <= bus.hdr_sel;
          err_q[wr_bank_q]     <= bus.err_inject;
          wr_bank_q            <= ~wr_bank_q;
          wr_ptr_q             <= 4'd0;
        end else begin
          wr_ptr_q <= wr_ptr_q + 4'd1;
        end
      end
    end
  end

  // Outputs are registered alongside the state, so tx_* always describe the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rd_bank_q     <= 1'b0;
      pos_q         <= 4'd0;
      tx_data_q     <= IDLE_BYTE;
      tx_sof_q      <= 1'b0;
      tx_active_q   <= 1'b0;
      frames_sent_q <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.tx_enable && full_q[rd_bank_q]) begin
            state_q     <= StHdrLsb;
            tx_data_q   <= hdr_lsb(hdr_sel_q[rd_bank_q]);
            tx_sof_q    <= 1'b1;
            tx_active_q <= 1'b1;
            pos_q       <= 4'd0;
          end
        end
        StHdrLsb: begin
          state_q   <= StHdrMsb;
          tx_data_q <= hdr_msb(hdr_sel_q[rd_bank_q], err_q[rd_bank_q]);
          tx_sof_q  <= 1'b0;
          pos_q     <= 4'd1;
        end
        StHdrMsb: begin
          state_q   <= StPayload;
          tx_data_q <= mem_q[rd_bank_q][0];
          pos_q     <= 4'd2;
        end
        StPayload: begin
          if (pos_q != LastPos) begin
            // Next position p+1 carries payload index p-1.
            tx_data_q <= mem_q[rd_bank_q][pos_q - 4'd1];
            pos_q     <= pos_q + 4'd1;
          end else begin
            rd_bank_q     <= nxt_bank;
            frames_sent_q <= frames_sent_q + 16'd1;
            pos_q         <= 4'd0;
            if (bus.tx_enable && full_q[nxt_bank]) begin
              state_q     <= StHdrLsb;
              tx_data_q   <= hdr_lsb(hdr_sel_q[nxt_bank]);
              tx_sof_q    <= 1'b1;
              tx_active_q <= 1'b1;
            end else begin
              state_q     <= StIdle;
              tx_data_q   <= IDLE_BYTE;
              tx_sof_q    <= 1'b0;
              tx_active_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          tx_data_q   <= IDLE_BYTE;
          tx_sof_q    <= 1'b0;
          tx_active_q <= 1'b0;
          pos_q       <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter: a byte-level scoreboard filled as banks complete and
// drained by a negedge monitor, plus directed checks of timing, gating, reset and counter wrap.
module tb_frame_transmitter;

  localparam logic [7:0] IDLE = 8'h00;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] pos;
    logic       sof;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  frame_transmitter_if bus ();

  frame_transmitter #(.IDLE_BYTE(IDLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] pay_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         idle_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every frame byte must match the scoreboard; idle cycles must carry the filler.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_active === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_frame_byte", 32'(bus.tx_active), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tx_data", 32'(bus.tx_data), 32'(e.data));
          check("tx_pos", 32'(bus.tx_byte_position), 32'(e.pos));
          check("tx_sof", 32'(bus.tx_sof), 32'(e.sof));
        end
      end else begin
        idle_cycles++;
        check("idle_data", 32'(bus.tx_data), 32'(IDLE));
        check("idle_pos", 32'(bus.tx_byte_position), 32'd0);
        check("idle_sof", 32'(bus.tx_sof), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard update: a completed bank yields one frame of expected bytes.
  task automatic model_accept(input logic [7:0] d, input logic sel, input logic err);
    exp_t e;
    logic [7:0] msb;
    pay_q.push_back(d);
    if (pay_q.size() == 10) begin
      if (sel) msb = err ? 8'h45 : 8'hBA;
      else     msb = err ? 8'h50 : 8'hAF;
      e = '{data: (sel ? 8'h55 : 8'hAA), pos: 4'd0, sof: 1'b1};
      exp_q.push_back(e);
      e = '{data: msb, pos: 4'd1, sof: 1'b0};
      exp_q.push_back(e);
      for (int i = 0; i < 10; i++) begin
        e = '{data: pay_q[i], pos: 4'(i + 2), sof: 1'b0};
        exp_q.push_back(e);
      end
      pay_q.delete();
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic sel, input logic err,
                           output int stalls);
    stalls = 0;
    bus.in_data    = d;
    bus.hdr_sel    = sel;
    bus.err_inject = err;
    bus.in_valid   = 1'b1;
    while (bus.in_ready !== 1'b1 && stalls < 100) begin
      tick();
      stalls++;
    end
    if (stalls >= 100) begin
      check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      tick();
      model_accept(d, sel, err);
    end
  endtask

  task automatic push_frame(input logic [7:0] base, input logic sel, input logic err);
    int st;
    for (int i = 0; i < 10; i++) begin
      push_byte(base + 8'(i), sel, (i == 9) ? err : 1'b0, st);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frames(input logic [15:0] target, input string tag);
    int n = 0;
    while (bus.frames_sent !== target && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.frames_sent), 32'(target));
  endtask

  task automatic wait_pos(input logic [3:0] p);
    int n = 0;
    while (!(bus.tx_active === 1'b1 && bus.tx_byte_position === p) && n < 100) begin
      tick();
      n++;
    end
    check("wait_pos", 32'(bus.tx_byte_position), 32'(p));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    pay_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int st;
    int idle0;
    bus.in_data    = 8'h00;
    bus.in_valid   = 1'b0;
    bus.hdr_sel    = 1'b0;
    bus.err_inject = 1'b0;
    bus.tx_enable  = 1'b1;
    do_reset();

    // Reset values
    check("rst_tx_data", 32'(bus.tx_data), 32'(IDLE));
    check("rst_sof", 32'(bus.tx_sof), 32'd0);
    check("rst_active", 32'(bus.tx_active), 32'd0);
    check("rst_pos", 32'(bus.tx_byte_position), 32'd0);
    check("rst_frames", 32'(bus.frames_sent), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single frame with fill-to-header latency
    for (int i = 0; i < 10; i++) push_byte(8'h01 + 8'(i), 1'b0, 1'b0, st);
    bus.in_valid = 1'b0;
    check("lat_not_yet", 32'(bus.tx_active), 32'd0);
    tick();
    check("lat_sof", 32'(bus.tx_sof), 32'd1);
    check("lat_hdr", 32'(bus.tx_data), 32'hAA);
    wait_frames(16'd1, "single_frames");
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back: 40 bytes, backpressure and no idle gap
    for (int i = 0; i < 40; i++) begin
      push_byte(8'h10 + 8'(i), 1'b1, 1'b0, st);
      if (i == 10) idle0 = idle_cycles;
      if (i == 19) check("bp_low", 32'(bus.in_ready), 32'd0);
      if (i == 20) check("bp_stall", 32'(st), 32'd3);
    end
    bus.in_valid = 1'b0;
    wait_frames(16'd5, "b2b_frames");
    check("b2b_gap", 32'(idle_cycles - idle0), 32'd0);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Error injection on frame 2 of 3
    do_reset();
    push_frame(8'h21, 1'b0, 1'b0);
    push_frame(8'h31, 1'b0, 1'b1);
    push_frame(8'h41, 1'b0, 1'b0);
    wait_frames(16'd3, "err_frames");
    check("err_drained", 32'(exp_q.size()), 32'd0);

    // tx_enable gating
    bus.tx_enable = 1'b0;
    push_frame(8'h60, 1'b0, 1'b0);
    repeat (5) tick();
    check("gate_idle", 32'(bus.tx_data), 32'(IDLE));
    check("gate_inactive", 32'(bus.tx_active), 32'd0);
    check("gate_in_ready", 32'(bus.in_ready), 32'd1);
    bus.tx_enable = 1'b1;
    tick();
    check("gate_sof", 32'(bus.tx_sof), 32'd1);
    wait_pos(4'd5);
    bus.tx_enable = 1'b0;
    wait_frames(16'd4, "gate_frames");
    check("gate_end_idle", 32'(bus.tx_active), 32'd0);
    check("gate_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with the other bank full
    push_frame(8'h70, 1'b1, 1'b0);
    push_frame(8'h80, 1'b0, 1'b0);
    check("both_full", 32'(bus.in_ready), 32'd0);
    bus.tx_enable = 1'b1;
    wait_pos(4'd6);
    reset = 1'b1;
    exp_q.delete();
    pay_q.delete();
    tick();
    reset = 1'b0;
    check("mid_rst_data", 32'(bus.tx_data), 32'(IDLE));
    check("mid_rst_active", 32'(bus.tx_active), 32'd0);
    check("mid_rst_frames", 32'(bus.frames_sent), 32'd0);
    repeat (30) tick();
    check("mid_rst_quiet", 32'(bus.tx_active), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    push_frame(8'h90, 1'b1, 1'b0);
    wait_frames(16'd1, "post_rst_frames");

    // Counter wrap
    force dut.frames_sent_q = 16'hFFFF;
    tick();
    release dut.frames_sent_q;
    tick();
    check("wrap_preset", 32'(bus.frames_sent), 32'hFFFF);
    push_frame(8'hA0, 1'b0, 1'b0);
    wait_frames(16'h0000, "wrap_frames");
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
